pmem_line_responder: RTL and testbench
======================================

Name: pmem_line_responder

Overview:
Physical-memory responder for the 256-bit line interface that the top level drives toward main memory (mem_read/mem_write/mem_addr/mem_wdata out, mem_resp/mem_rdata in). It accepts one line transaction at a time, models a fixed access latency, stores lines in an internal array, and pulses mem_resp for exactly one cycle per transaction. It is the synthesizable memory-side end of the L2 miss path, used both on FPGA and as the bench memory.

Parameters:
DEPTH_BITS, 6, log2 of line count in the internal array (64 lines = 2 KB)
LATENCY, 8, cycles from request acceptance to the mem_resp pulse; legal range 1..255
LINE_BITS, 256, line width; fixed, not to be overridden

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
mem_read  in  1  line read request, held high by the requester until mem_resp
mem_write  in  1  line write request, held high by the requester until mem_resp
mem_addr  in  32  byte address; bits [4:0] ignored (line aligned)
mem_wdata  in  256  write line data
mem_resp  out  1  one-cycle completion pulse
mem_rdata  out  256  read line data, valid in the mem_resp cycle
protocol_err  out  1  sticky: read and write were both high at acceptance
rd_count  out  16  completed reads, wraps at 0xFFFF -> 0
wr_count  out  16  completed writes, wraps at 0xFFFF -> 0

Behaviour:
- Reset (async assert, sync-to-clk deassert is the requester's concern): state IDLE; mem_resp=0, mem_rdata=0, protocol_err=0, rd_count=0, wr_count=0, latency counter=0. Array contents are not reset.
- FSM states: IDLE, BUSY, RESP.
- IDLE: if mem_read|mem_write is sampled high -> latch op, index = mem_addr[4+DEPTH_BITS:5], and mem_wdata; load counter with LATENCY-1; go to BUSY. If LATENCY=1, go directly to RESP.
- BUSY: decrement the counter each cycle; when it reaches 0, go to RESP. Total cycles from the acceptance edge to mem_resp high = LATENCY.
- RESP: mem_resp=1 (registered output, high for exactly one cycle). For a write, the array is updated at the RESP edge. For a read, mem_rdata is loaded from the array at the edge entering RESP. The matching counter increments by 1. Next state is IDLE.
- mem_rdata holds its last read value until the next read completes. Writes do not change it.
- Back-to-back: a request sampled in the first IDLE cycle after RESP is accepted. The minimum period is LATENCY+1 cycles.
- Read and write both high at acceptance: the write is performed, protocol_err is set, and it stays set until reset.
- Address, data or op changes during BUSY are ignored, because the latched values are used.
- Request dropped during BUSY: the transaction still completes and mem_resp still pulses.
- Upper address bits above 4+DEPTH_BITS are ignored, so addresses alias modulo 2^DEPTH_BITS lines.
- Read-after-write to the same line returns the new data, because the write commits at RESP before the next acceptance.
- Reset asserted mid-transaction: the transaction is aborted and no array write occurs unless the RESP edge has already happened.

Decomposition:
- Add a shared package pmem_types containing: the LINE_BITS=256 constant, the line_t typedef (logic [255:0]), and the enum pmem_state_t {IDLE, BUSY, RESP}.
- Sub-module pmem_line_ram: single-port 2^DEPTH_BITS x 256 array with synchronous write and registered read, so it can be inferred as BRAM. The FSM, counter and statistics logic stay in the top module.

Test Plan:
- Reset with rst_n=0 for 3 cycles, then release -> all outputs 0; first mem_read of addr 0x00000040 produces exactly one mem_resp, 8 cycles after acceptance (LATENCY=8).
- Write addr 0x00000080, data {8{32'hDEADBEEF}}; then read addr 0x00000080 -> mem_rdata = {8{32'hDEADBEEF}} in the resp cycle; wr_count=1, rd_count=1.
- Alias: with DEPTH_BITS=6, write 0x00000000 with all-ones, read 0x00000800 -> all-ones returned; read 0x0000001F -> the same line.
- mem_read and mem_write both high, addr 0x100, data 0x5A repeated -> protocol_err=1 and stays 1; a subsequent read of 0x100 returns 0x5A repeated; wr_count increments and rd_count does not until that later read.
- Drop mem_read 2 cycles after acceptance and change mem_addr -> mem_resp still pulses at cycle 8 with data from the originally latched address.
- Assert rst_n=0 during BUSY of a write to 0x200 -> no mem_resp; after release, reading 0x200 returns the prior contents; with LATENCY=1, the back-to-back period is measured as 2 cycles.

Source files
------------

// File: rtl/pmem_types.sv
// Shared types for the physical-memory line responder.
package pmem_types;

  localparam int unsigned LINE_BITS = 256;

  typedef logic [LINE_BITS-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } pmem_state_t;

endpackage

// File: rtl/pmem_line_ram.sv
// Single-port line array: synchronous write, registered read (BRAM-friendly).
module pmem_line_ram
  import pmem_types::*;
#(
  parameter int unsigned DEPTH_BITS = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_BITS-1:0] addr,
  input  line_t                 wdata,
  output line_t                 rdata
);

  line_t mem [0:(1 << DEPTH_BITS)-1];

  // Array storage, intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read register: holds the last line read until the next read enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/pmem_line_responder.sv
// Memory-side responder for the 256-bit line interface: fixed latency,
// one transaction at a time, one-cycle mem_resp pulse per transaction.
module pmem_line_responder
  import pmem_types::*;
#(
  parameter int unsigned DEPTH_BITS = 6,
  parameter int unsigned LATENCY    = 8   // legal range 1..255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [31:0]          mem_addr,
  input  logic [LINE_BITS-1:0] mem_wdata,
  output logic                 mem_resp,
  output logic [LINE_BITS-1:0] mem_rdata,
  output logic                 protocol_err,
  output logic [15:0]          rd_count,
  output logic [15:0]          wr_count
);

  localparam logic [7:0] LOAD = 8'(LATENCY - 1);

  pmem_state_t           state;
  pmem_state_t           state_next;
  logic [7:0]            cnt;
  logic                  op_write;
  logic [DEPTH_BITS-1:0] idx;
  logic [DEPTH_BITS-1:0] req_idx;
  logic [DEPTH_BITS-1:0] ram_addr;
  line_t                 wdata_q;
  logic                  req;
  logic                  ram_we;
  logic                  ram_re;
  logic                  unused_addr_bits;

  assign req              = mem_read | mem_write;
  assign req_idx          = mem_addr[4+DEPTH_BITS:5];
  assign unused_addr_bits = ^{mem_addr[31:5+DEPTH_BITS], mem_addr[4:0]};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and array control. The registered read is issued on the
  // cycle before RESP so mem_rdata is valid while mem_resp is high; with
  // LATENCY=1 that cycle is the acceptance cycle, so the live address is used.
  always_comb begin
    state_next = state;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_addr   = idx;
    case (state)
      IDLE: begin
        if (req) begin
          ram_addr = req_idx;
          if (LATENCY == 1) begin
            state_next = RESP;
            ram_re     = ~mem_write;
          end else begin
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt <= 8'd1) begin
          state_next = RESP;
          ram_re     = ~op_write;
        end
      end
      RESP: begin
        state_next = IDLE;
        ram_we     = op_write;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latch, latency counter, response pulse and statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      op_write     <= 1'b0;
      idx          <= '0;
      wdata_q      <= '0;
      mem_resp     <= 1'b0;
      protocol_err <= 1'b0;
      rd_count     <= '0;
      wr_count     <= '0;
    end else begin
      mem_resp <= (state_next == RESP);
      if (state == IDLE && req) begin
        op_write <= mem_write;
        idx      <= req_idx;
        wdata_q  <= mem_wdata;
        cnt      <= LOAD;
        if (mem_read && mem_write) begin
          protocol_err <= 1'b1;
        end
      end else if (state == BUSY) begin
        cnt <= cnt - 8'd1;
      end
      if (state == RESP) begin
        if (op_write) begin
          wr_count <= wr_count + 16'd1;
        end else begin
          rd_count <= rd_count + 16'd1;
        end
      end
    end
  end

  pmem_line_ram #(
    .DEPTH_BITS (DEPTH_BITS)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_pmem_line_responder.sv
// Self-checking bench for pmem_line_responder: timeline reference model plus
// directed literal checks; a second instance covers LATENCY=1.
module tb_pmem_line_responder;
  import pmem_types::*;

  localparam int unsigned LAT = 8;
  localparam int unsigned DB  = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read, mem_write, mem_resp, protocol_err;
  logic [31:0] mem_addr;
  line_t       mem_wdata, mem_rdata;
  logic [15:0] rd_count, wr_count;

  logic        r_read, r_write, r_resp, r_err;
  logic [31:0] r_addr;
  line_t       r_wdata, r_rdata;
  logic [15:0] r_rdc, r_wrc;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pmem_line_responder #(.DEPTH_BITS(DB), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_resp(mem_resp),
    .mem_rdata(mem_rdata), .protocol_err(protocol_err),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  pmem_line_responder #(.DEPTH_BITS(DB), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .mem_read(r_read), .mem_write(r_write),
    .mem_addr(r_addr), .mem_wdata(r_wdata), .mem_resp(r_resp),
    .mem_rdata(r_rdata), .protocol_err(r_err),
    .rd_count(r_rdc), .wr_count(r_wrc)
  );

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic line_t rline();
    line_t v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference model: lines by index, transaction timeline by edge number.
  line_t       mdl [64];
  bit          known [64];
  bit          busy;
  int          resp_edge;
  bit          m_wr;
  int          m_idx;
  line_t       m_data;
  bit          e_resp, e_err, e_rd_known;
  line_t       e_rdata;
  logic [15:0] e_rdc, e_wrc;

  function automatic void mreset();
    busy       = 1'b0;
    e_resp     = 1'b0;
    e_err      = 1'b0;
    e_rdata    = '0;
    e_rd_known = 1'b1;
    e_rdc      = '0;
    e_wrc      = '0;
  endfunction

  initial begin : model
    int k;
    k = 0;
    mreset();
    forever begin
      @(posedge clk);
      k++;
      if (!rst_n) begin
        mreset();
      end else begin
        if (busy && k == resp_edge + 1) begin
          if (m_wr) begin
            mdl[m_idx]   = m_data;
            known[m_idx] = 1'b1;
            e_wrc++;
          end else begin
            e_rdc++;
          end
          busy = 1'b0;
        end else if (!busy && (mem_read || mem_write)) begin
          busy      = 1'b1;
          resp_edge = k + LAT - 1;
          m_wr      = mem_write;
          m_idx     = int'(mem_addr[10:5]);
          m_data    = mem_wdata;
          if (mem_read && mem_write) e_err = 1'b1;
        end
        if (busy && k == resp_edge && !m_wr) begin
          e_rdata    = mdl[m_idx];
          e_rd_known = known[m_idx];
        end
        e_resp = busy && (k == resp_edge);
      end
      @(negedge clk);
      if (!rst_n) mreset();
      chk("resp", mem_resp, e_resp);
      chk("err", protocol_err, e_err);
      chk("rd_count", rd_count, e_rdc);
      chk("wr_count", wr_count, e_wrc);
      if (e_rd_known) chk("rdata", mem_rdata, e_rdata);
    end
  end

  // Called #1 after a posedge with the DUT idle; returns #1 after the edge
  // that leaves the response cycle, with the request deasserted.
  task automatic txn(input bit rd, input bit wr, input logic [31:0] a, input line_t d,
                     input int drop_at, output line_t q, output int lat);
    int n;
    bit seen;
    mem_read  = rd;
    mem_write = wr;
    mem_addr  = a;
    mem_wdata = d;
    n    = 0;
    seen = 1'b0;
    q    = '0;
    while (!seen && n < 40) begin
      @(posedge clk);
      n++;
      if (n == drop_at) begin
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = $urandom;
        mem_wdata = rline();
      end
      @(negedge clk);
      if (mem_resp) begin
        seen = 1'b1;
        q    = mem_rdata;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL txn_timeout: actual=no_resp required=resp addr=%h", a);
    end
    lat = n;
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic wait_r(output int t);
    int n;
    n = 0;
    t = -1;
    while (t < 0 && n < 10) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (r_resp) t = cyc;
    end
    if (t < 0) begin
      total++;
      bad++;
      $display("FAIL r_timeout: actual=no_resp required=resp");
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin : stim
    line_t q, dd, pp;
    line_t ones, beef, five_a;
    int    lat, t0, t1, t2, t3;
    ones   = '1;
    beef   = {8{32'hDEADBEEF}};
    five_a = {32{8'h5A}};
    mem_read = 0; mem_write = 0; mem_addr = '0; mem_wdata = '0;
    r_read = 0; r_write = 0; r_addr = '0; r_wdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_resp", mem_resp, 1'b0);
    chk("rst_rdata", mem_rdata, '0);
    chk("rst_counts", {rd_count, wr_count, 15'd0, protocol_err}, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    txn(1, 0, 32'h0000_0040, '0, 0, q, lat);
    chk("first_latency", lat, 8);

    txn(0, 1, 32'h0000_0080, beef, 0, q, lat);
    txn(1, 0, 32'h0000_0080, '0, 0, q, lat);
    chk("raw_data", q, beef);
    chk("raw_latency", lat, 8);
    chk("raw_rd_count", rd_count, 16'd2);
    chk("raw_wr_count", wr_count, 16'd1);

    txn(0, 1, 32'h0000_0000, ones, 0, q, lat);
    txn(1, 0, 32'h0000_0800, '0, 0, q, lat);
    chk("alias_high", q, ones);
    txn(1, 0, 32'h0000_001F, '0, 0, q, lat);
    chk("alias_low", q, ones);

    txn(1, 1, 32'h0000_0100, five_a, 0, q, lat);
    chk("both_err", protocol_err, 1'b1);
    chk("both_wr_count", wr_count, 16'd3);
    chk("both_rd_count", rd_count, 16'd4);
    txn(1, 0, 32'h0000_0100, '0, 0, q, lat);
    chk("both_data", q, five_a);
    chk("both_rd_after", rd_count, 16'd5);
    chk("err_sticky", protocol_err, 1'b1);

    dd = rline();
    txn(0, 1, 32'h0000_0140, dd, 0, q, lat);
    txn(1, 0, 32'h0000_0140, '0, 3, q, lat);
    chk("drop_data", q, dd);
    chk("drop_latency", lat, 8);

    for (int i = 0; i < 80; i++) begin
      int          op, drop, gap;
      bit          rd, wr;
      logic [31:0] a;
      op   = $urandom_range(0, 9);
      rd   = (op < 5) || (op == 9);
      wr   = (op >= 5);
      a    = ($urandom & 32'hFFFF_F800) | (32'($urandom_range(0, 7)) << 5) | 32'($urandom_range(0, 31));
      drop = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 7) : 0;
      txn(rd, wr, a, rline(), drop, q, lat);
      chk("rand_latency", lat, 8);
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end

    pp = rline();
    txn(0, 1, 32'h0000_0200, pp, 0, q, lat);
    mem_write = 1'b1;
    mem_addr  = 32'h0000_0200;
    mem_wdata = ~pp;
    repeat (3) @(posedge clk);
    #1;
    rst_n     = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    chk("abort_resp", mem_resp, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("abort_wr_count", wr_count, 16'd0);
    txn(1, 0, 32'h0000_0200, '0, 0, q, lat);
    chk("abort_prior_data", q, pp);
    chk("abort_rd_count", rd_count, 16'd1);
    chk("abort_err_clear", protocol_err, 1'b0);

    dd = rline();
    pp = rline();
    r_write = 1'b1;
    r_addr  = 32'h0000_03E0;
    r_wdata = dd;
    t0 = cyc;
    wait_r(t1);
    chk("l1_latency", t1 - t0, 1);
    @(posedge clk);
    #1 r_wdata = pp;
    wait_r(t2);
    chk("l1_period_wr", t2 - t1, 2);
    @(posedge clk);
    #1;
    r_write = 1'b0;
    r_read  = 1'b1;
    wait_r(t3);
    chk("l1_period_rd", t3 - t2, 2);
    chk("l1_data", r_rdata, pp);
    @(posedge clk);
    #1 r_read = 1'b0;
    chk("l1_wr_count", r_wrc, 16'd2);
    chk("l1_rd_count", r_rdc, 16'd1);
    chk("l1_err", r_err, 1'b0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
